cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory-side responder for the CPU core's data port. It accepts the core's address (`aluout`), byte write enables (`memwen`) and store data (`writedata`), and returns `readdata` one cycle later. Requests are served from an on-chip word-addressed data RAM or from a small memory-mapped peripheral window:

- LED output register
- switch input
- free-running cycle counter with compare/interrupt

The block sits between `mips` and the board top level.

## Interface

Parameters:
- `DEPTH_LOG2`, default 12: RAM depth is 2^DEPTH_LOG2 32-bit words.
- `MMIO_BASE`, default 16'hBFAF: value of `addr[31:16]` that selects the peripheral window.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `aluout`, input, 32: byte address from the core. Only word-aligned addresses are used; `addr[1:0]` is ignored.
- `memwen`, input, 4: byte write enables. Bit i writes `writedata[8i+7:8i]`. 4'b0000 means no write.
- `writedata`, input, 32: store data.
- `readdata`, output, 32: registered read data.
- `sw`, input, 16: board switches.
- `led`, output, 16: LED register.
- `irq`, output, 1: timer match flag.

## Operation

Address decode (per cycle, on `aluout`):
- If `aluout[31:16] == MMIO_BASE`, the access goes to MMIO.
- Otherwise it goes to RAM at word index `aluout[DEPTH_LOG2+1:2]`. Upper bits alias.

RAM:
- Every cycle is a read of the addressed word. A write occurs when `memwen != 0`.
- Per-byte masked write.
- Read-first: a read and write to the same word in the same cycle returns the old data.
- Contents are not reset.

MMIO map (offset = `aluout[15:0]`). All writes are byte-masked by `memwen`:
- 16'hF000 LED: RW. Bits [15:0] drive `led`; reads return {16'b0, led}.
- 16'hF004 SWITCH: RO. Reads return {16'b0, sw} as sampled at the rising edge. Writes are ignored.
- 16'hE000 COUNT: RW, 32-bit. Increments by 1 every cycle and wraps FFFF_FFFF→0. A write loads the masked value instead of incrementing that cycle; write beats increment.
- 16'hE004 COMPARE: RW, 32-bit.
- 16'hE008 STATUS: bit0 = match flag; other bits read 0.
  - Writing 1 to bit0 (with `memwen[0]` set) clears the flag.
  - Writing 0 has no effect.
- Any other MMIO offset: reads return 0; writes are ignored, with no side effects.

Timer match:
- The flag sets on the edge after any cycle in which COUNT (current register value) equals COMPARE.
- If a set and a write-1-clear happen in the same cycle, set wins.
- `irq` equals the flag.

## Timing

- Read latency is 1 cycle. `readdata` at edge n+1 reflects the address presented in cycle n, with state as it was before that cycle's write.
- MMIO reads are read-first, like RAM. A read of COUNT returns its pre-increment value.
- Write latency is 1 cycle. State is visible to a read issued in the next cycle.
- Reset values:
  - `readdata` = 0
  - `led` = 0
  - COUNT = 0
  - COMPARE = 32'hFFFF_FFFF
  - flag / `irq` = 0
- While `rst` is asserted, writes are ignored and COUNT holds at 0.
- After reset deasserts, COUNT reads 0 in the first cycle and increments from there.
- Reset in the middle of a write drops the write.
- COMPARE resets to all-ones, so there is no spurious match until 2^32-1 cycles.
- No handshake or stalls: every cycle is accepted.

## Test plan

1. **RAM byte-enable write.** Write 32'h11223344 to 0x0000_0010 with 4'b1111. Then write 32'hAABBCCDD with 4'b0101. Read 0x10 → 32'h11BB33DD one cycle after the address is presented.
2. **Read-first and aliasing.** With `DEPTH_LOG2`=12, in the same cycle read and write (32'hCAFEF00D) address 0x20, which holds 32'h5. `readdata` = 32'h5. The next read of 0x20 → 32'hCAFEF00D. A read of 0x4020 also returns 32'hCAFEF00D.
3. **LED and switch.**
   - Write 32'hFFFF_A5A5 to 0xBFAF_F000 → `led` = 16'hA5A5 next cycle; readback = 32'h0000_A5A5.
   - Set `sw` = 16'h1234 and read 0xBFAF_F004 → 32'h0000_1234.
   - Writing 0xBFAF_F004 changes nothing.
4. **Timer match.**
   - After reset, write COMPARE = 10. Write COUNT = 5 (that cycle, COUNT does not increment).
   - `irq` rises exactly 6 cycles after the COUNT write edge.
   - Write 1 to STATUS → `irq` = 0 next cycle, and stays 0 while COUNT ≠ 10.
5. **Set/clear collision and wrap.**
   - Write COUNT = 32'hFFFF_FFFE and COMPARE = 32'h0. The flag sets after the wrap.
   - Issue a STATUS clear in the same cycle COUNT == 0 → the flag remains 1.
6. **Synchronous reset mid-run.** Assert `rst` for 1 cycle while writing LED = 16'hFFFF. Afterwards `led` = 0, `irq` = 0, `readdata` = 0, and COUNT reads 0 in the first post-reset cycle. RAM retains its prior data.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Data-port responder for the CPU core: word-addressed RAM plus a small MMIO window
// (LED register, switch input, free-running counter with compare match flag).
module cpu_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [15:0] MMIO_BASE  = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluout,
  input  logic [3:0]  memwen,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned DW    = 32;

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF004;
  localparam logic [15:0] OFF_COUNT   = 16'hE000;
  localparam logic [15:0] OFF_COMPARE = 16'hE004;
  localparam logic [15:0] OFF_STATUS  = 16'hE008;

  logic [DW-1:0]         mem [DEPTH];
  logic [DW-1:0]         count;
  logic [DW-1:0]         compare;
  logic [DW-1:0]         bmask;
  logic [DW-1:0]         mmio_rd;
  logic [DW-1:0]         count_wr_val;
  logic [DW-1:0]         compare_wr_val;
  logic [15:0]           led_wr_val;
  logic [15:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  is_mmio;
  logic                  wr_any;
  logic                  match;
  logic                  status_clr;

  assign is_mmio = (aluout[31:16] == MMIO_BASE);
  assign offset  = aluout[15:0];
  assign idx     = aluout[DEPTH_LOG2+1:2];
  assign wr_any  = |memwen;
  assign match   = (count == compare);

  // Byte-enable expansion and masked merge values for the writable registers
  always_comb begin
    bmask = '0;
    for (int i = 0; i < 4; i++) begin
      bmask[8*i +: 8] = {8{memwen[i]}};
    end
    count_wr_val   = (count & ~bmask) | (writedata & bmask);
    compare_wr_val = (compare & ~bmask) | (writedata & bmask);
    led_wr_val     = (led & ~bmask[15:0]) | (writedata[15:0] & bmask[15:0]);
    status_clr     = is_mmio && (offset == OFF_STATUS) && memwen[0] && writedata[0];
  end

  // MMIO read mux; unmapped offsets read as zero
  always_comb begin
    mmio_rd = '0;
    case (offset)
      OFF_LED:     mmio_rd = {16'h0, led};
      OFF_SWITCH:  mmio_rd = {16'h0, sw};
      OFF_COUNT:   mmio_rd = count;
      OFF_COMPARE: mmio_rd = compare;
      OFF_STATUS:  mmio_rd = {31'h0, irq};
      default:     mmio_rd = '0;
    endcase
  end

  // RAM: byte-masked write, contents not reset
  always_ff @(posedge clk) begin
    if (!rst && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (memwen[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  // Registered read, read-first for both RAM and MMIO
  always_ff @(posedge clk) begin
    if (rst) readdata <= '0;
    else     readdata <= is_mmio ? mmio_rd : mem[idx];
  end

  // Peripheral state; a counter write overrides that cycle's increment
  always_ff @(posedge clk) begin
    if (rst) begin
      led     <= '0;
      count   <= '0;
      compare <= '1;
      irq     <= 1'b0;
    end else begin
      if (is_mmio && wr_any && offset == OFF_LED) led <= led_wr_val;
      if (is_mmio && wr_any && offset == OFF_COUNT) count <= count_wr_val;
      else                                          count <= count + DW'(1);
      if (is_mmio && wr_any && offset == OFF_COMPARE) compare <= compare_wr_val;
      irq <= match | (irq & ~status_clr);
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized and directed bench for cpu_mem_responder against a behavioural
// model of the RAM, peripheral registers and timer flag.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aluout;
  logic [3:0]  memwen;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic        irq;

  cpu_mem_responder #(.DEPTH_LOG2(12), .MMIO_BASE(16'hBFAF)) dut (
    .clk(clk), .rst(rst), .aluout(aluout), .memwen(memwen),
    .writedata(writedata), .readdata(readdata), .sw(sw), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_ram [int];
  logic [15:0] m_led;
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic        m_flag;
  logic [31:0] m_rd;
  bit          m_rd_known;
  logic [15:0] cur_sw = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One clock: apply inputs, advance the model, check every output after the edge
  task automatic step(input logic r, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d);
    logic        mm;
    logic [15:0] off;
    int          wi;
    logic [31:0] nc;
    logic [31:0] tmp;
    logic        hit;
    logic        clr;
    rst = r; aluout = a; memwen = be; writedata = d; sw = cur_sw;
    if (r) begin
      m_rd = 32'h0; m_rd_known = 1; m_led = 16'h0; m_cnt = 32'h0;
      m_cmp = 32'hFFFF_FFFF; m_flag = 1'b0;
    end else begin
      mm  = (a[31:16] == 16'hBFAF);
      off = a[15:0];
      wi  = int'((a >> 2) & 32'hFFF);
      hit = (m_cnt == m_cmp);
      clr = 1'b0;
      nc  = m_cnt + 32'd1;
      m_rd_known = 1;
      if (mm) begin
        case (off)
          16'hF000: m_rd = {16'h0, m_led};
          16'hF004: m_rd = {16'h0, cur_sw};
          16'hE000: m_rd = m_cnt;
          16'hE004: m_rd = m_cmp;
          16'hE008: m_rd = {31'h0, m_flag};
          default:  m_rd = 32'h0;
        endcase
        if (be != 4'h0) begin
          case (off)
            16'hF000: begin tmp = merge({16'h0, m_led}, d, be); m_led = tmp[15:0]; end
            16'hE000: nc = merge(m_cnt, d, be);
            16'hE004: m_cmp = merge(m_cmp, d, be);
            16'hE008: clr = be[0] & d[0];
            default: ;
          endcase
        end
      end else begin
        m_rd_known = m_ram.exists(wi);
        m_rd = m_rd_known ? m_ram[wi] : 32'h0;
        if (be == 4'hF)                   m_ram[wi] = d;
        else if (be != 4'h0 && m_rd_known) m_ram[wi] = merge(m_ram[wi], d, be);
        else if (be != 4'h0)              m_ram.delete(wi);
      end
      m_cnt  = nc;
      m_flag = hit | (m_flag & ~clr);
    end
    @(posedge clk);
    #1;
    if (m_rd_known) check("readdata", readdata, m_rd);
    check("led", {16'h0, led}, {16'h0, m_led});
    check("irq", {31'h0, irq}, {31'h0, m_flag});
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1'b0, a, be, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, a, 4'h0, 32'h0);
  endtask

  localparam logic [31:0] A_LED = 32'hBFAF_F000;
  localparam logic [31:0] A_SW  = 32'hBFAF_F004;
  localparam logic [31:0] A_CNT = 32'hBFAF_E000;
  localparam logic [31:0] A_CMP = 32'hBFAF_E004;
  localparam logic [31:0] A_ST  = 32'hBFAF_E008;

  initial begin
    logic [31:0] addrs [12];
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    addrs = '{32'h0, 32'h4, 32'h8, 32'h4004, 32'h3C, A_LED, A_SW, A_CNT, A_CMP, A_ST,
              32'hBFAF_F008, 32'hBFAF_E00C};
    rst = 1'b1; aluout = 32'h0; memwen = 4'h0; writedata = 32'h0; sw = 16'h0;
    @(negedge clk);
    step(1'b1, 32'h0, 4'h0, 32'h0);
    step(1'b1, 32'h0, 4'h0, 32'h0);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rd(A_CNT);
    check("count_first_cycle", readdata, 32'h0);
    rd(A_CMP);
    check("compare_reset", readdata, 32'hFFFF_FFFF);

    // RAM byte enables
    wr(32'h10, 4'hF, 32'h1122_3344);
    wr(32'h10, 4'h5, 32'hAABB_CCDD);
    rd(32'h10);
    check("ram_byte_en", readdata, 32'h11BB_33DD);

    // Read-first and aliasing
    wr(32'h20, 4'hF, 32'h5);
    wr(32'h20, 4'hF, 32'hCAFE_F00D);
    check("ram_read_first", readdata, 32'h5);
    rd(32'h20);
    check("ram_new_data", readdata, 32'hCAFE_F00D);
    rd(32'h4020);
    check("ram_alias", readdata, 32'hCAFE_F00D);

    // LED and switch
    wr(A_LED, 4'hF, 32'hFFFF_A5A5);
    check("led_value", {16'h0, led}, 32'h0000_A5A5);
    rd(A_LED);
    check("led_readback", readdata, 32'h0000_A5A5);
    cur_sw = 16'h1234;
    rd(A_SW);
    check("switch_read", readdata, 32'h0000_1234);
    wr(A_SW, 4'hF, 32'hFFFF_FFFF);
    rd(A_SW);
    check("switch_ro", readdata, 32'h0000_1234);
    check("led_unchanged", {16'h0, led}, 32'h0000_A5A5);

    // Timer match: irq rises exactly 6 edges after the COUNT write edge
    step(1'b1, 32'h0, 4'h0, 32'h0);
    wr(A_CMP, 4'hF, 32'd10);
    wr(A_CNT, 4'hF, 32'd5);
    for (int k = 1; k <= 6; k++) begin
      rd(32'h10);
      check($sformatf("irq_edge%0d", k), {31'h0, irq}, {31'h0, (k == 6)});
    end
    wr(A_ST, 4'h1, 32'h1);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      rd(A_ST);
      check("irq_stays_clear", {31'h0, irq}, 32'h0);
    end

    // Wrap and set-beats-clear collision
    wr(A_CNT, 4'hF, 32'hFFFF_FFFE);
    wr(A_CMP, 4'hF, 32'h0);
    rd(A_CNT);
    check("count_pre_wrap", readdata, 32'hFFFF_FFFF);
    check("no_flag_before_wrap", {31'h0, irq}, 32'h0);
    wr(A_ST, 4'h1, 32'h1);
    check("set_beats_clear", {31'h0, irq}, 32'h1);
    wr(A_ST, 4'h1, 32'h1);
    check("clear_after_collision", {31'h0, irq}, 32'h0);

    // Reset mid-write
    wr(32'h30, 4'hF, 32'hDEAD_BEEF);
    wr(A_LED, 4'hF, 32'h0000_1234);
    wr(A_CNT, 4'hF, 32'd7);
    wr(A_CMP, 4'hF, 32'd8);
    rd(A_LED);
    rd(A_LED);
    check("irq_before_reset", {31'h0, irq}, 32'h1);
    step(1'b1, A_LED, 4'hF, 32'h0000_FFFF);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    rd(A_CNT);
    check("rst_count", readdata, 32'h0);
    rd(32'h30);
    check("ram_retained", readdata, 32'hDEAD_BEEF);

    // Randomized traffic; timer values kept small so matches happen
    for (int n = 0; n < 600; n++) begin
      a  = addrs[$urandom_range(0, 11)];
      be = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) be = 4'h0;
      d  = $urandom;
      if (a == A_CNT || a == A_CMP) d = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) cur_sw = 16'($urandom);
      step(($urandom_range(0, 60) == 0), a, be, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
